// File: rtl/wordle_scorer.sv
// Wordle scorer: takes a 5-letter guess and secret, returns green/yellow/gray per position.
// Latency: accept edge + 10 edges (5 green passes, 5 yellow passes) to result_valid.
// Backpressure: guess_ready only in IDLE; the result is held in DONE until result_ack.
// Optional WORDLE_SCORER_CHARCHECK_EN: adds bad_char and rejects guesses with non 'A'..'Z' characters.
module wordle_scorer #(
    parameter int N_LETTERS = 5,
    parameter int CHAR_W    = 8
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          guess_valid,
    output logic                          guess_ready,
    input  logic [N_LETTERS*CHAR_W-1:0]   guess_word,
    input  logic [N_LETTERS*CHAR_W-1:0]   secret_word,
    output logic                          result_valid,
    input  logic                          result_ack,
    output logic [2*N_LETTERS-1:0]        colors,
`ifdef WORDLE_SCORER_CHARCHECK_EN
    output logic                          bad_char,
`endif
    output logic                          all_green,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

    localparam logic [2:0]               LAST      = 3'(N_LETTERS - 1);
    localparam logic [2*N_LETTERS-1:0]   ALL_GREEN = {N_LETTERS{2'b10}};

    state_t state, next_state;

    // Element 0 of each packed array is the first letter (most significant byte).
    logic [0:N_LETTERS-1][CHAR_W-1:0] guess_r;
    logic [0:N_LETTERS-1][CHAR_W-1:0] secret_r;
    logic [0:N_LETTERS-1][1:0]        col_r;
    logic [N_LETTERS-1:0]             used;
    logic [2:0]                       idx;

    logic       idx_ok;
    logic       idx_last;
    logic       skip;
    logic       hit;
    logic [2:0] hit_j;

    assign idx_ok   = (idx <= LAST);
    assign idx_last = (idx == LAST);

`ifdef WORDLE_SCORER_CHARCHECK_EN
    logic bad_in;
    logic bad_pend;

    // Flag any incoming guess character outside 'A'..'Z'.
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (guess_word[CHAR_W*i +: CHAR_W] < 8'h41 || guess_word[CHAR_W*i +: CHAR_W] > 8'h5A)
                bad_in = 1'b1;
        end
    end

    // Bad guesses take one pass through GREEN and then jump straight to DONE.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            bad_pend <= 1'b0;
            bad_char <= 1'b0;
        end else if (state == IDLE && guess_valid) begin
            bad_pend <= bad_in;
            bad_char <= 1'b0;
        end else if (state == GREEN && bad_pend) begin
            bad_pend <= 1'b0;
            bad_char <= 1'b1;
        end
    end

    assign skip = bad_pend;
`else
    assign skip = 1'b0;
`endif

    // Lowest unused secret position matching the current guess letter.
    always_comb begin
        hit   = 1'b0;
        hit_j = 3'd0;
        for (int j = N_LETTERS - 1; j >= 0; j--) begin
            if (!used[j] && secret_r[j] == guess_r[idx]) begin
                hit   = 1'b1;
                hit_j = 3'(j);
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode; an out-of-range idx abandons the operation.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (guess_valid) next_state = GREEN;
            GREEN: begin
                if (!idx_ok)       next_state = IDLE;
                else if (skip)     next_state = DONE;
                else if (idx_last) next_state = YELLOW;
            end
            YELLOW: begin
                if (!idx_ok)       next_state = IDLE;
                else if (idx_last) next_state = DONE;
            end
            DONE:   if (result_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch words on accept, then green pass and yellow pass one letter per cycle.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            guess_r   <= '0;
            secret_r  <= '0;
            col_r     <= '0;
            used      <= '0;
            idx       <= 3'd0;
            all_green <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (guess_valid) begin
                        guess_r   <= guess_word;
                        secret_r  <= secret_word;
                        col_r     <= '0;
                        used      <= '0;
                        idx       <= 3'd0;
                        all_green <= 1'b0;
                    end
                end
                GREEN: begin
                    if (!idx_ok || skip) begin
                        idx <= 3'd0;
                    end else begin
                        if (guess_r[idx] == secret_r[idx]) begin
                            col_r[idx] <= 2'b10;
                            used[idx]  <= 1'b1;
                        end
                        idx <= idx_last ? 3'd0 : idx + 3'd1;
                    end
                end
                YELLOW: begin
                    if (!idx_ok) begin
                        idx <= 3'd0;
                    end else begin
                        if (col_r[idx] != 2'b10 && hit) begin
                            col_r[idx]  <= 2'b01;
                            used[hit_j] <= 1'b1;
                        end
                        // Yellow updates never touch greens, so the win flag is known now.
                        if (idx_last) all_green <= (col_r == ALL_GREEN);
                        idx <= idx_last ? 3'd0 : idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign colors       = col_r;
    assign guess_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state == GREEN) || (state == YELLOW);

endmodule

// File: tb/tb_wordle_scorer.sv
// Self-checking bench for wordle_scorer: directed cases plus random words against a letter-count model.
module tb_wordle_scorer;

    logic        Clk = 1'b0;
    logic        reset;
    logic        guess_valid;
    logic        guess_ready;
    logic [39:0] guess_word;
    logic [39:0] secret_word;
    logic        result_valid;
    logic        result_ack;
    logic [9:0]  colors;
    logic        all_green;
    logic        busy;
`ifdef WORDLE_SCORER_CHARCHECK_EN
    logic        bad_char;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    wordle_scorer dut (
        .Clk          (Clk),
        .reset        (reset),
        .guess_valid  (guess_valid),
        .guess_ready  (guess_ready),
        .guess_word   (guess_word),
        .secret_word  (secret_word),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .colors       (colors),
`ifdef WORDLE_SCORER_CHARCHECK_EN
        .bad_char     (bad_char),
`endif
        .all_green    (all_green),
        .busy         (busy)
    );

    // Standard Wordle scoring via leftover-letter counts.
    function automatic logic [9:0] model(input logic [39:0] g, input logic [39:0] s);
        int          cnt [256];
        logic [7:0]  gc, sc;
        logic [9:0]  res;
        bit          grn [5];
        res = '0;
        foreach (cnt[k]) cnt[k] = 0;
        for (int i = 0; i < 5; i++) begin
            gc = g[8*(4-i) +: 8];
            sc = s[8*(4-i) +: 8];
            grn[i] = (gc == sc);
            if (grn[i]) res[8-2*i +: 2] = 2'b10;
            else        cnt[sc]++;
        end
        for (int i = 0; i < 5; i++) begin
            gc = g[8*(4-i) +: 8];
            if (!grn[i] && cnt[gc] > 0) begin
                res[8-2*i +: 2] = 2'b01;
                cnt[gc]--;
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for result_valid after the accept edge; returns number of edges after accept.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!result_valid && edges < 40) begin
            @(negedge Clk);
            edges++;
        end
    endtask

    // Full transaction: accept, check latency/colours/flag, ack, check return to IDLE.
    task automatic score(input string tag, input logic [39:0] g, input logic [39:0] s);
        int         edges;
        logic [9:0] exp;
        exp = model(g, s);
        @(negedge Clk);
        chk({tag, "_ready"}, 32'(guess_ready), 32'd1);
        guess_word  = g;
        secret_word = s;
        guess_valid = 1'b1;
        @(negedge Clk);
        guess_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_result(edges);
        chk({tag, "_lat"}, 32'(edges), 32'd10);
        chk({tag, "_col"}, 32'(colors), 32'(exp));
        chk({tag, "_ag"}, 32'(all_green), 32'(exp == 10'b1010101010));
        result_ack = 1'b1;
        @(negedge Clk);
        result_ack = 1'b0;
        chk({tag, "_idle"}, {30'd0, guess_ready, result_valid}, 32'b10);
        chk({tag, "_hold"}, 32'(colors), 32'(exp));
    endtask

    initial begin
        int         edges;
        logic [39:0] g, s;
        logic [9:0]  exp;
        logic        stable;

        reset       = 1'b1;
        guess_valid = 1'b0;
        guess_word  = '0;
        secret_word = '0;
        result_ack  = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_state", {26'd0, guess_ready, result_valid, all_green, busy, 2'b00}, 32'b100000);
        chk("rst_colors", 32'(colors), 32'd0);
        reset = 1'b0;

        // Directed scoring cases, including duplicate-letter rules.
        score("robot", "ROBOT", "ROBOT");
        chk("robot_const", 32'(model("ROBOT", "ROBOT")), 32'b1010101010);
        score("boots", "BOOTS", "ROBOT");
        chk("boots_const", 32'(model("BOOTS", "ROBOT")), 32'b0110010100);
        score("bbbbb", "BBBBB", "ABBOT");
        chk("bbbbb_const", 32'(model("BBBBB", "ABBOT")), 32'b0010100000);
        score("papal", "PAPAL", "LAPSE");
        chk("papal_const", 32'(model("PAPAL", "LAPSE")), 32'b0010100001);

        // Hold valid and change the guess mid-scoring: only the first word counts.
        @(negedge Clk);
        guess_word  = "BOOTS";
        secret_word = "ROBOT";
        guess_valid = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        guess_word  = "ROBOT";
        secret_word = "ROBOT";
        edges = 0;
        wait_result(edges);
        chk("hs_lat", 32'(edges), 32'd9);
        chk("hs_col", 32'(colors), 32'b0110010100);
        chk("hs_ag", 32'(all_green), 32'd0);

        // No ack for 20 cycles: result must stay put.
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (!result_valid || colors !== 10'b0110010100) stable = 1'b0;
        end
        chk("hs_stable", 32'(stable), 32'd1);

        // Ack with valid still high: first edge returns to IDLE only, next edge accepts.
        result_ack = 1'b1;
        @(negedge Clk);
        result_ack = 1'b0;
        chk("hs_ack_idle", {30'd0, guess_ready, busy}, 32'b10);
        @(negedge Clk);
        guess_valid = 1'b0;
        chk("hs_reaccept", 32'(busy), 32'd1);
        wait_result(edges);
        chk("hs_re_col", 32'(colors), 32'b1010101010);
        result_ack = 1'b1;
        @(negedge Clk);
        result_ack = 1'b0;

        // Reset during the yellow pass discards everything.
        guess_word  = "BOOTS";
        secret_word = "ROBOT";
        guess_valid = 1'b1;
        @(negedge Clk);
        guess_valid = 1'b0;
        repeat (6) @(negedge Clk);
        chk("ry_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("ry_rst", {29'd0, guess_ready, result_valid, busy}, 32'b100);
        chk("ry_col", 32'(colors), 32'd0);
        @(negedge Clk);
        reset = 1'b0;
        score("cacao", "CACAO", "AAAAA");

        // Random words from a small alphabet so duplicates are common.
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 5; i++) begin
                g[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 4));
                s[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 4));
            end
            if (n % 5 == 0) g = s;
            score($sformatf("rnd%0d", n), g, s);
        end

`ifdef WORDLE_SCORER_CHARCHECK_EN
        // Non-letter guess goes straight to DONE on the second edge.
        @(negedge Clk);
        guess_word  = "RO8OT";
        secret_word = "ROBOT";
        guess_valid = 1'b1;
        @(negedge Clk);
        guess_valid = 1'b0;
        wait_result(edges);
        chk("bc_lat", 32'(edges), 32'd1);
        chk("bc_flag", {30'd0, bad_char, all_green}, 32'b10);
        chk("bc_col", 32'(colors), 32'd0);
        result_ack = 1'b1;
        @(negedge Clk);
        result_ack = 1'b0;
        score("bc_next", "ROBOT", "ROBOT");
        chk("bc_clear", 32'(bad_char), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
